// File: rtl/tcnt_axi_burst_addr_gen_pkg.sv
// rtl/tcnt_axi_burst_addr_gen_pkg.sv - shared AXI enums plus burst address generator types
package tcnt_axi_burst_addr_gen_pkg;

   typedef enum logic [2:0] {
      SIZE_1B   = 3'd0,
      SIZE_2B   = 3'd1,
      SIZE_4B   = 3'd2,
      SIZE_8B   = 3'd3,
      SIZE_16B  = 3'd4,
      SIZE_32B  = 3'd5,
      SIZE_64B  = 3'd6,
      SIZE_128B = 3'd7
   } burst_size_enum;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2,
      BURST_RSVD  = 2'd3
   } burst_type_enum;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'd0,
      RESP_EXOKAY = 2'd1,
      RESP_SLVERR = 2'd2,
      RESP_DECERR = 2'd3
   } resp_type_enum;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } gen_state_e;

   localparam int BOUNDARY_4K_BITS = 12;

endpackage

// File: rtl/tcnt_axi_beat_addr_calc.sv
// rtl/tcnt_axi_beat_addr_calc.sv - combinational next-beat address for FIXED/INCR/WRAP
module tcnt_axi_beat_addr_calc
   import tcnt_axi_burst_addr_gen_pkg::*;
#(
   parameter int ADDR_W = 64
) (
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [7:0]        i_len,
   input  logic [2:0]        i_size,
   input  burst_type_enum    i_burst,
   output logic [ADDR_W-1:0] o_next_addr
);

   logic [ADDR_W-1:0] w_nbytes;
   logic [ADDR_W-1:0] w_aligned;
   logic [ADDR_W-1:0] w_incr;
   logic [ADDR_W-1:0] w_total;
   logic [ADDR_W-1:0] w_lo;
   logic [ADDR_W-1:0] w_wrap;

   assign w_nbytes  = ADDR_W'(1) << i_size;
   assign w_aligned = i_addr & ~(w_nbytes - ADDR_W'(1));
   assign w_incr    = w_aligned + w_nbytes;
   assign w_total   = ADDR_W'({1'b0, i_len} + 9'd1) << i_size;
   assign w_lo      = i_addr & ~(w_total - ADDR_W'(1));
   assign w_wrap    = w_lo | (w_incr & (w_total - ADDR_W'(1)));

   // The top already demotes reserved and malformed WRAP bursts to INCR.
   always_comb begin
      o_next_addr = w_incr;
      case (i_burst)
         BURST_FIXED: o_next_addr = i_addr;
         BURST_WRAP:  o_next_addr = w_wrap;
         default:     o_next_addr = w_incr;
      endcase
   end

endmodule

// File: rtl/tcnt_axi_burst_addr_gen.sv
// rtl/tcnt_axi_burst_addr_gen.sv - expands one AXI address-phase command into beat descriptors
module tcnt_axi_burst_addr_gen
   import tcnt_axi_burst_addr_gen_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int ID_W   = 8,
   parameter int DATA_W = 64
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [7:0]        cmd_len,
   input  logic [2:0]        cmd_size,
   input  logic [1:0]        cmd_burst,
   input  logic [ID_W-1:0]   cmd_id,
   output logic              beat_valid,
   input  logic              beat_ready,
   output logic [ADDR_W-1:0] beat_addr,
   output logic [7:0]        beat_idx,
   output logic              beat_last,
   output logic [ID_W-1:0]   beat_id,
   output logic [1:0]        beat_resp,
   output logic              busy
);

   localparam int MAX_SIZE = $clog2(DATA_W / 8);

   gen_state_e        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_idx;
   logic [7:0]        r_len;
   logic [2:0]        r_size;
   burst_type_enum    r_burst;
   logic [ID_W-1:0]   r_id;
   resp_type_enum     r_resp;
   logic              r_last;
   logic              r_valid;
   logic              r_busy;

   logic              w_beat_hs;
   logic              w_cmd_ready;
   logic              w_cmd_hs;
   logic [ADDR_W-1:0] w_nbytes;
   logic [ADDR_W-1:0] w_last_addr;
   logic [ADDR_W-1:0] w_next_addr;
   logic              w_is_incr;
   logic              w_is_wrap;
   logic              w_size_err;
   logic              w_rsvd_err;
   logic              w_wrap_len_err;
   logic              w_wrap_align_err;
   logic              w_4k_err;
   logic              w_err;
   burst_type_enum    w_eff_burst;

   assign w_beat_hs   = r_valid && beat_ready;
   assign w_cmd_ready = aresetn && ((r_state == ST_IDLE) || (w_beat_hs && r_last));
   assign w_cmd_hs    = cmd_valid && w_cmd_ready;

   assign w_is_incr   = (cmd_burst == 2'(BURST_INCR));
   assign w_is_wrap   = (cmd_burst == 2'(BURST_WRAP));
   assign w_nbytes    = ADDR_W'(1) << cmd_size;
   assign w_last_addr = (cmd_addr & ~(w_nbytes - ADDR_W'(1))) + (ADDR_W'(cmd_len) << cmd_size);

   assign w_size_err       = int'(cmd_size) > MAX_SIZE;
   assign w_rsvd_err       = (cmd_burst == 2'(BURST_RSVD));
   assign w_wrap_len_err   = w_is_wrap && !(cmd_len == 8'd1 || cmd_len == 8'd3 ||
                                            cmd_len == 8'd7 || cmd_len == 8'd15);
   assign w_wrap_align_err = w_is_wrap && ((cmd_addr & (w_nbytes - ADDR_W'(1))) != '0);
   assign w_4k_err         = w_is_incr && (w_last_addr[ADDR_W-1:BOUNDARY_4K_BITS] !=
                                           cmd_addr[ADDR_W-1:BOUNDARY_4K_BITS]);
   assign w_err = w_size_err || w_rsvd_err || w_wrap_len_err || w_wrap_align_err || w_4k_err;

   // Malformed WRAP and reserved bursts still walk INCR addresses for the full length.
   assign w_eff_burst = (w_rsvd_err || w_wrap_len_err || w_wrap_align_err) ?
                        BURST_INCR : burst_type_enum'(cmd_burst);

   tcnt_axi_beat_addr_calc #(.ADDR_W(ADDR_W)) u_addr_calc (
      .i_addr      (r_addr),
      .i_len       (r_len),
      .i_size      (r_size),
      .i_burst     (r_burst),
      .o_next_addr (w_next_addr)
   );

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_idx   <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_burst <= BURST_FIXED;
         r_id    <= '0;
         r_resp  <= RESP_OKAY;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else if (w_cmd_hs) begin
         r_state <= ST_BURST;
         r_addr  <= cmd_addr;
         r_idx   <= '0;
         r_len   <= cmd_len;
         r_size  <= cmd_size;
         r_burst <= w_eff_burst;
         r_id    <= cmd_id;
         r_resp  <= w_err ? RESP_SLVERR : RESP_OKAY;
         r_last  <= (cmd_len == 8'd0);
         r_valid <= 1'b1;
         r_busy  <= 1'b1;
      end else if (w_beat_hs) begin
         if (r_last) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            r_addr <= w_next_addr;
            r_idx  <= r_idx + 8'd1;
            r_last <= ((r_idx + 8'd1) == r_len);
         end
      end
   end

   assign cmd_ready  = w_cmd_ready;
   assign beat_valid = r_valid;
   assign beat_addr  = r_addr;
   assign beat_idx   = r_idx;
   assign beat_last  = r_last;
   assign beat_id    = r_id;
   assign beat_resp  = r_resp;
   assign busy       = r_busy;

endmodule

// File: tb/tb_tcnt_axi_burst_addr_gen.sv
// tb/tb_tcnt_axi_burst_addr_gen.sv - directed scoreboard bench for the burst address generator
module tb_tcnt_axi_burst_addr_gen;

   localparam int ADDR_W = 64;
   localparam int ID_W   = 8;
   localparam int DATA_W = 64;

   localparam logic [1:0] B_FIXED = 2'd0;
   localparam logic [1:0] B_INCR  = 2'd1;
   localparam logic [1:0] B_WRAP  = 2'd2;
   localparam logic [1:0] B_RSVD  = 2'd3;
   localparam logic [1:0] OKAY    = 2'd0;
   localparam logic [1:0] SLVERR  = 2'd2;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        idx;
      logic              last;
      logic [ID_W-1:0]   id;
      logic [1:0]        resp;
   } beat_t;

   logic              aclk = 1'b0;
   logic              aresetn = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [7:0]        cmd_len = '0;
   logic [2:0]        cmd_size = '0;
   logic [1:0]        cmd_burst = '0;
   logic [ID_W-1:0]   cmd_id = '0;
   logic              beat_valid;
   logic              beat_ready = 1'b1;
   logic [ADDR_W-1:0] beat_addr;
   logic [7:0]        beat_idx;
   logic              beat_last;
   logic [ID_W-1:0]   beat_id;
   logic [1:0]        beat_resp;
   logic              busy;

   int    checks = 0;
   int    errors = 0;
   int    rdy_mode = 0;
   beat_t exp_q[$];

   tcnt_axi_burst_addr_gen #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_len    (cmd_len),
      .cmd_size   (cmd_size),
      .cmd_burst  (cmd_burst),
      .cmd_id     (cmd_id),
      .beat_valid (beat_valid),
      .beat_ready (beat_ready),
      .beat_addr  (beat_addr),
      .beat_idx   (beat_idx),
      .beat_last  (beat_last),
      .beat_id    (beat_id),
      .beat_resp  (beat_resp),
      .busy       (busy)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Consumer readiness: 0 always ready, 1 random.
   always @(posedge aclk) begin
      #1;
      beat_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   logic              prev_stall = 1'b0;
   logic [ADDR_W+19:0] prev_snap = '0;
   logic [ADDR_W+19:0] cur_snap;
   assign cur_snap = {beat_valid, beat_addr, beat_idx, beat_last, beat_id, beat_resp};

   always @(negedge aclk) begin
      beat_t e;
      if (aresetn && prev_stall)
         chk("stall_stable", 128'(cur_snap), 128'(prev_snap));
      prev_stall = aresetn && beat_valid && !beat_ready;
      prev_snap  = cur_snap;
      if (aresetn && beat_valid && beat_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 128'(beat_addr), 128'hdead);
         end else begin
            e = exp_q.pop_front();
            chk("beat_addr", 128'(beat_addr), 128'(e.addr));
            chk("beat_idx",  128'(beat_idx),  128'(e.idx));
            chk("beat_last", 128'(beat_last), 128'(e.last));
            chk("beat_id",   128'(beat_id),   128'(e.id));
            chk("beat_resp", 128'(beat_resp), 128'(e.resp));
         end
      end
   end

   task automatic push(input logic [ADDR_W-1:0] a, input logic [7:0] i, input logic l,
                       input logic [ID_W-1:0] id, input logic [1:0] r);
      beat_t e;
      e.addr = a; e.idx = i; e.last = l; e.id = id; e.resp = r;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [ADDR_W-1:0] a, input logic [7:0] l, input logic [2:0] s,
                       input logic [1:0] b, input logic [ID_W-1:0] id, output int cyc);
      bit done = 0;
      cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b; cmd_id = id;
      cmd_valid = 1'b1;
      cyc = 0;
      while (!done && cyc < 100) begin
         @(negedge aclk);
         if (cmd_ready) done = 1;
         @(posedge aclk);
         cyc++;
      end
      #1 cmd_valid = 1'b0;
      chk("cmd_handshake", 128'(done), 128'(1));
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || beat_valid) && n < 300) begin
         @(negedge aclk);
         n++;
      end
      chk("drain_timeout", 128'(n < 300), 128'(1));
      chk("idle_busy", 128'(busy), 128'(0));
      @(posedge aclk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, 128'(beat_valid), 128'(0));
      chk({tag, "_busy"},  128'(busy),       128'(0));
      chk({tag, "_ready"}, 128'(cmd_ready),  128'(0));
      chk({tag, "_beat"},  128'({beat_addr, beat_idx, beat_last, beat_id, beat_resp}), 128'(0));
   endtask

   initial begin
      int cyc;
      int n;
      repeat (3) @(posedge aclk);
      #1 check_reset_outputs("por");
      aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("ready_after_reset", 128'(cmd_ready), 128'(1));

      // Aligned INCR
      for (int i = 0; i < 4; i++) push(64'h1004 + 64'(4 * i), 8'(i), i == 3, 8'd1, OKAY);
      send(64'h1004, 8'd3, 3'd2, B_INCR, 8'd1, cyc);
      chk("first_latency", 128'(cyc), 128'(1));
      chk("busy_in_burst", 128'({busy, beat_valid}), 128'(2'b11));
      drain();

      // Unaligned INCR
      push(64'h1003, 8'd0, 1'b0, 8'd2, OKAY);
      push(64'h1004, 8'd1, 1'b0, 8'd2, OKAY);
      push(64'h1008, 8'd2, 1'b1, 8'd2, OKAY);
      send(64'h1003, 8'd2, 3'd2, B_INCR, 8'd2, cyc);
      drain();

      // WRAP
      push(64'h1038, 8'd0, 1'b0, 8'd3, OKAY);
      push(64'h1020, 8'd1, 1'b0, 8'd3, OKAY);
      push(64'h1028, 8'd2, 1'b0, 8'd3, OKAY);
      push(64'h1030, 8'd3, 1'b1, 8'd3, OKAY);
      send(64'h1038, 8'd3, 3'd3, B_WRAP, 8'd3, cyc);
      drain();

      // FIXED
      for (int i = 0; i < 3; i++) push(64'h2000, 8'(i), i == 2, 8'd4, OKAY);
      send(64'h2000, 8'd2, 3'd2, B_FIXED, 8'd4, cyc);
      drain();

      // WRAP with illegal length walks INCR addresses
      for (int i = 0; i < 3; i++) push(64'h1000 + 64'(4 * i), 8'(i), i == 2, 8'd5, SLVERR);
      send(64'h1000, 8'd2, 3'd2, B_WRAP, 8'd5, cyc);
      drain();

      // INCR crossing 4KB
      push(64'h0FF8, 8'd0, 1'b0, 8'd6, SLVERR);
      push(64'h1000, 8'd1, 1'b1, 8'd6, SLVERR);
      send(64'h0FF8, 8'd1, 3'd3, B_INCR, 8'd6, cyc);
      drain();

      // Size wider than the bus
      push(64'h5000, 8'd0, 1'b0, 8'd7, SLVERR);
      push(64'h5010, 8'd1, 1'b1, 8'd7, SLVERR);
      send(64'h5000, 8'd1, 3'd4, B_INCR, 8'd7, cyc);
      drain();

      // Reserved burst type
      push(64'h6000, 8'd0, 1'b0, 8'd8, SLVERR);
      push(64'h6004, 8'd1, 1'b1, 8'd8, SLVERR);
      send(64'h6000, 8'd1, 3'd2, B_RSVD, 8'd8, cyc);
      drain();

      // Back-to-back single-beat commands
      push(64'h7000, 8'd0, 1'b1, 8'd9, OKAY);
      push(64'h7100, 8'd0, 1'b1, 8'd10, OKAY);
      send(64'h7000, 8'd0, 3'd2, B_INCR, 8'd9, cyc);
      send(64'h7100, 8'd0, 3'd2, B_INCR, 8'd10, cyc);
      chk("b2b_no_bubble", 128'(cyc), 128'(1));
      chk("b2b_second_valid", 128'({beat_valid, beat_addr}), 128'({1'b1, 64'h7100}));
      drain();

      // Random backpressure
      rdy_mode = 1;
      for (int i = 0; i < 8; i++) push(64'h4000 + 64'(8 * i), 8'(i), i == 7, 8'd11, OKAY);
      send(64'h4000, 8'd7, 3'd3, B_INCR, 8'd11, cyc);
      drain();
      rdy_mode = 0;

      // Reset in the middle of an eight-beat burst
      for (int i = 0; i < 8; i++) push(64'h3000 + 64'(4 * i), 8'(i), i == 7, 8'd12, OKAY);
      send(64'h3000, 8'd7, 3'd2, B_INCR, 8'd12, cyc);
      n = 0;
      while (!(beat_valid && beat_idx == 8'd2) && n < 50) begin
         @(negedge aclk);
         n++;
      end
      chk("reach_beat2", 128'(n < 50), 128'(1));
      #1 aresetn = 1'b0;
      @(posedge aclk); #1;
      check_reset_outputs("mid_reset");
      exp_q.delete();
      aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("ready_after_mid_reset", 128'(cmd_ready), 128'(1));
      push(64'h8000, 8'd0, 1'b0, 8'd13, OKAY);
      push(64'h8004, 8'd1, 1'b1, 8'd13, OKAY);
      send(64'h8000, 8'd1, 3'd2, B_INCR, 8'd13, cyc);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
